// File: rtl/fetch_pkg.sv
// Fetch unit shared types: FSM states, default widths, buffer entry.
// Build option RETURN_STACK_EN adds a 4-entry return-address stack.
package fetch_pkg;

    localparam int ADDR_W_DEF  = 12;
    localparam int INSTR_W_DEF = 19;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FULL
    } fetch_state_e;

    typedef struct packed {
        logic [ADDR_W_DEF-1:0]  pc;
        logic [INSTR_W_DEF-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory port and decode handshake.
// Optional return stack (RETURN_STACK_EN) does not change this bundle.
interface fetch_unit_if import fetch_pkg::*; #(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
);

    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_data;

    logic               out_valid;
    logic               out_ready;
    logic [INSTR_W-1:0] out_instr;
    logic [ADDR_W-1:0]  out_pc;

    modport master (
        output imem_req, imem_addr,
        input  imem_ack, imem_data,
        output out_valid, out_instr, out_pc,
        input  out_ready
    );

    modport slave (
        input  imem_req, imem_addr,
        output imem_ack, imem_data,
        input  out_valid, out_instr, out_pc,
        output out_ready
    );

endinterface

// File: rtl/fetch_fifo.sv
// Fetch buffer: DEPTH-entry FIFO (power of two) with synchronous flush.
// Not affected by RETURN_STACK_EN.
module fetch_fifo import fetch_pkg::*; #(
    parameter int  DEPTH = 2,
    parameter type T     = fetch_entry_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  T                         din,
    output T                         dout,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0] CNT_MAX = (PW+1)'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (count != CNT_MAX || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (do_pop && !do_push)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, memory request FSM, fetch buffer.
// Define RETURN_STACK_EN to compile in the 4-entry return-address stack.
module fetch_unit import fetch_pkg::*; #(
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int INSTR_W   = INSTR_W_DEF,
    parameter int BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_in,
    output logic [ADDR_W-1:0] next_pc,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              ret_pop,
    input  logic              call_push,
    input  logic [ADDR_W-1:0] call_ret_pc,
    fetch_unit_if.master      bus
);

    typedef struct packed {
        logic [ADDR_W-1:0]  pc;
        logic [INSTR_W-1:0] instr;
    } entry_t;

    localparam int CW = $clog2(BUF_DEPTH);
    localparam logic [CW:0] CNT_MAX = (CW+1)'(BUF_DEPTH);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic              drop_q;
    logic              drop_d;
    logic              busy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] imem_addr;
    logic              req;
    logic              ack;
    logic              push;
    logic              pop;
    logic              flush;
    logic              empty;
    logic [CW:0]       count;
    logic [CW:0]       count_nx;
    entry_t            din;
    entry_t            dout;
    logic              ret_hit;
    logic [ADDR_W-1:0] ret_pc;

`ifdef RETURN_STACK_EN
    logic [ADDR_W-1:0] ras [4];
    logic [1:0]        ras_top;
    logic [2:0]        ras_cnt;
    logic              ras_push;
    logic              ras_pop;

    // A redirect from execute squashes the decode-side stack operation.
    assign ras_push = !redirect_valid && call_push && !ret_pop;
    assign ras_pop  = !redirect_valid && ret_pop && !call_push;
    assign ret_hit  = ret_pop;

    always_comb begin
        ret_pc = '0;
        if (call_push)
            ret_pc = call_ret_pc;
        else if (ras_cnt != 3'd0)
            ret_pc = ras[ras_top];
    end

    always_ff @(posedge clk) begin
        if (!rst && ras_push)
            ras[ras_top + 2'd1] <= call_ret_pc;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ras_top <= '0;
            ras_cnt <= '0;
        end else if (ras_push) begin
            ras_top <= ras_top + 2'd1;
            if (ras_cnt != 3'd4)
                ras_cnt <= ras_cnt + 3'd1;
        end else if (ras_pop && ras_cnt != 3'd0) begin
            ras_top <= ras_top - 2'd1;
            ras_cnt <= ras_cnt - 3'd1;
        end
    end
`else
    logic unused_ras;

    assign unused_ras = ^{ret_pop, call_push, call_ret_pc};
    assign ret_hit    = 1'b0;
    assign ret_pc     = '0;
`endif

    assign req   = (state_q == REQ);
    assign ack   = req && bus.imem_ack;
    assign flush = redirect_valid || ret_hit;
    assign push  = ack && !drop_q && !flush;
    assign pop   = !empty && bus.out_ready && !flush;
    assign din   = '{pc: pc_in, instr: bus.imem_data};

    // Hold the issued address while the memory has not answered.
    assign imem_addr = !req   ? '0 :
                       busy_q ? addr_q : pc_in;

    always_comb begin
        count_nx = count;
        if (flush)
            count_nx = '0;
        else if (push && !pop)
            count_nx = count + 1'b1;
        else if (pop && !push)
            count_nx = count - 1'b1;
    end

    always_comb begin
        next_pc = pc_in;
        if (redirect_valid)
            next_pc = redirect_pc;
        else if (ret_hit)
            next_pc = ret_pc;
        else if (push)
            next_pc = pc_in + 1'b1;
    end

    always_comb begin
        state_d = state_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (bus.imem_ack)
                    drop_d = 1'b0;
                else if (flush)
                    drop_d = 1'b1;
                if (count_nx == CNT_MAX)
                    state_d = FULL;
            end
            FULL: begin
                if (count_nx != CNT_MAX)
                    state_d = REQ;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            drop_q  <= 1'b0;
            busy_q  <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            drop_q  <= drop_d;
            busy_q  <= req && !bus.imem_ack;
            addr_q  <= imem_addr;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH),
        .T     (entry_t)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .push  (push),
        .pop   (pop),
        .din   (din),
        .dout  (dout),
        .empty (empty),
        .count (count)
    );

    assign bus.imem_req  = req;
    assign bus.imem_addr = imem_addr;
    assign bus.out_valid = !empty;
    assign bus.out_pc    = empty ? '0 : dout.pc;
    assign bus.out_instr = empty ? '0 : dout.instr;

endmodule
